// File: rtl/meatsquare_engine_if.sv
// Meatsquare engine controller/pixel bus.
// Master is the game controller, slave is the engine.
interface meatsquare_engine_if;
   logic       update;
   logic       draw_squares;
   logic [7:0] catcher_x;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       finish_drawing_squares;
   logic [2:0] catch_count;
   logic [2:0] miss_count;
   logic       score_valid;

   modport master (
      output update, draw_squares, catcher_x,
      input  x, y, colour, finish_drawing_squares,
      input  catch_count, miss_count, score_valid
   );

   modport slave (
      input  update, draw_squares, catcher_x,
      output x, y, colour, finish_drawing_squares,
      output catch_count, miss_count, score_valid
   );
endinterface

// File: rtl/meatsquare_engine.sv
// Falling-square engine: moves, scores and draws four squares.
// Define SQUARE_LFSR_EN for LFSR-based respawn columns.
module meatsquare_engine #(
   parameter int         NUM_SQ    = 4,
   parameter int         SQ_SIZE   = 4,
   parameter int         CATCHER_Y = 112,
   parameter int         CATCHER_W = 16,
   parameter logic [2:0] SQ_COLOUR = 3'b100
) (
   input logic                clock,
   input logic                reset,
   meatsquare_engine_if.slave bus
);

   typedef enum logic [2:0] {IDLE, MOVE, ERASE, DRAW, DONE} state_t;

   localparam logic [6:0] Y_TOP = 7'(CATCHER_Y - SQ_SIZE);
   localparam logic [6:0] Y_MAX = 7'(120 - SQ_SIZE);

   state_t state, state_nxt;
   logic [6:0] cnt;
   logic       done_seen;
   logic [7:0] sq_x   [NUM_SQ];
   logic [6:0] sq_y   [NUM_SQ];
   logic [7:0] prev_x [NUM_SQ];
   logic [6:0] prev_y [NUM_SQ];
   logic [7:0] rx     [NUM_SQ];
   logic [6:0] y_nxt  [NUM_SQ];
   logic [NUM_SQ-1:0] hit, lost;
   logic [2:0] n_catch, n_miss;
   logic [2:0] catch_q, miss_q;
   logic       valid_q;
   logic [1:0] sel;

   function automatic logic [7:0] home_x(input logic [1:0] i);
      case (i)
         2'd0:    home_x = 8'd24;
         2'd1:    home_x = 8'd64;
         2'd2:    home_x = 8'd104;
         default: home_x = 8'd136;
      endcase
   endfunction

`ifdef SQUARE_LFSR_EN
   logic [7:0] lfsr;

   // free-running LFSR, taps 8,6,5,4
   always_ff @(posedge clock) begin
      if (!reset) lfsr <= 8'hA5;
      else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   // respawn column per square from the LFSR
   always_comb begin
      for (int i = 0; i < NUM_SQ; i++)
         rx[i] = ((lfsr ^ 8'(i * 8'h35)) & 8'h7F) + 8'd16;
   end
`else
   logic [1:0] idx;

   // table rotation index, steps on MOVEs that respawn
   always_ff @(posedge clock) begin
      if (!reset) idx <= 2'd0;
      else if (state == MOVE && |(hit | lost)) idx <= idx + 2'd1;
   end

   // respawn column per square from the rotated table
   always_comb begin
      for (int i = 0; i < NUM_SQ; i++)
         rx[i] = home_x(idx + 2'(i));
   end
`endif

   // catch / miss detection for the next row step
   always_comb begin
      n_catch = '0;
      n_miss  = '0;
      hit     = '0;
      lost    = '0;
      for (int i = 0; i < NUM_SQ; i++) begin
         y_nxt[i] = sq_y[i] + 7'd1;
         hit[i] = (sq_y[i] < Y_TOP) && (y_nxt[i] >= Y_TOP)
               && ({1'b0, sq_x[i]} + 9'(SQ_SIZE) > {1'b0, bus.catcher_x})
               && ({1'b0, sq_x[i]} < {1'b0, bus.catcher_x} + 9'(CATCHER_W));
         lost[i] = (y_nxt[i] > Y_MAX) && !hit[i];
         n_catch = n_catch + {2'b0, hit[i]};
         n_miss  = n_miss + {2'b0, lost[i]};
      end
   end

   // state register
   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   end

   // next state: update beats draw in IDLE
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (bus.update) state_nxt = MOVE;
            else if (bus.draw_squares) state_nxt = ERASE;
         end
         MOVE: state_nxt = IDLE;
         ERASE, DRAW: begin
            if (cnt == 7'd127) state_nxt = DONE;
            else if (cnt[3:0] == 4'hF) state_nxt = cnt[4] ? ERASE : DRAW;
         end
         DONE: if (!bus.draw_squares) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // pixel counter and DONE-entry tracking
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt       <= 7'd0;
         done_seen <= 1'b0;
      end else begin
         cnt       <= (state == ERASE || state == DRAW) ? cnt + 7'd1 : 7'd0;
         done_seen <= (state == DONE);
      end
   end

   // square positions; prev keeps the old spot for erasing
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SQ; i++) begin
            sq_x[i]   <= home_x(2'(i));
            sq_y[i]   <= 7'(30 * i);
            prev_x[i] <= home_x(2'(i));
            prev_y[i] <= 7'(30 * i);
         end
      end else if (state == MOVE) begin
         for (int i = 0; i < NUM_SQ; i++) begin
            prev_x[i] <= sq_x[i];
            prev_y[i] <= sq_y[i];
            sq_x[i]   <= (hit[i] || lost[i]) ? rx[i] : sq_x[i];
            sq_y[i]   <= (hit[i] || lost[i]) ? 7'd0 : y_nxt[i];
         end
      end
   end

   // score report, valid only in the cycle after MOVE
   always_ff @(posedge clock) begin
      if (!reset) begin
         valid_q <= 1'b0;
         catch_q <= 3'd0;
         miss_q  <= 3'd0;
      end else begin
         valid_q <= (state == MOVE);
         catch_q <= (state == MOVE) ? n_catch : 3'd0;
         miss_q  <= (state == MOVE) ? n_miss : 3'd0;
      end
   end

   assign sel = cnt[6:5];

   // pixel output, zero outside ERASE/DRAW
   always_comb begin
      bus.x      = 8'd0;
      bus.y      = 7'd0;
      bus.colour = 3'd0;
      if (state == ERASE) begin
         bus.x = prev_x[sel] + {6'd0, cnt[1:0]};
         bus.y = prev_y[sel] + {5'd0, cnt[3:2]};
      end else if (state == DRAW) begin
         bus.x      = sq_x[sel] + {6'd0, cnt[1:0]};
         bus.y      = sq_y[sel] + {5'd0, cnt[3:2]};
         bus.colour = SQ_COLOUR;
      end
   end

   assign bus.finish_drawing_squares = (state == DONE) && !done_seen;
   assign bus.score_valid = valid_q;
   assign bus.catch_count = catch_q;
   assign bus.miss_count  = miss_q;

endmodule
